fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the program counter and the single port of the instruction memory (prgrom).
- Decides each cycle whether the port is used for CPU instruction fetch or for a UART boot loader writing program words.
- Sequences the processor through load, start-up, run and ecall-halt phases, and drives the core enable.
- Sits between the UART loader, the ALU/branch unit (jump target and flag), the decoder (ecall) and the instruction ROM.

Parameters:
- ADDR_W, 14, instruction-memory word-address width; the byte PC maps to pc[ADDR_W+1:2].
- RESET_PC, 32'h00000000, PC value loaded at start-up.
- BOOT_LOAD, 1, 1 = leave reset in LOAD; 0 = leave reset in FLUSH and skip loading.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- jump_flag  in  1  redirect PC this cycle (valid in RUN only).
- jump_target  in  32  redirect address from ALU_result.
- ecall_flag  in  1  decoder flags the current instruction as ecall.
- resume  in  1  level from debounced button; its rising edge ends HALT.
- ld_req  in  1  loader has a word to write; held until ld_ack.
- ld_addr  in  ADDR_W  loader word address.
- ld_data  in  32  loader write data.
- ld_done  in  1  single-cycle pulse: load complete.
- pc_out  out  32  current PC.
- imem_addr  out  ADDR_W  instruction memory address.
- imem_we  out  1  instruction memory write enable.
- imem_wdata  out  32  instruction memory write data.
- ld_ack  out  1  one-cycle write acknowledge to the loader.
- cpu_en  out  1  core may commit the current instruction.
- halted  out  1  high in HALT.
- misalign_err  out  1  sticky: a jump target had nonzero bits [1:0].
- instret  out  32  count of committed instructions.

Behaviour:
- Reset (async, while rst_n=0):
  - state = LOAD if BOOT_LOAD else FLUSH.
  - pc_out=RESET_PC, ld_ack=0, imem_we=0, imem_wdata=0, cpu_en=0, halted=0, misalign_err=0, instret=0.
  - The resume edge detector is cleared.
- Reset asserted mid-write aborts the write: imem_we drops immediately and the word is not guaranteed written.
- Instruction memory is synchronous read with 1-cycle latency. In FLUSH/RUN/HALT, imem_addr = next_pc[ADDR_W+1:2] (combinational), so the ROM output matches pc_out in the cycle pc_out holds that value.
- LOAD:
  - cpu_en=0, PC held.
  - When ld_req=1 and ld_ack=0, the next cycle drives imem_we=1, ld_ack=1, and registered copies of ld_addr/ld_data on imem_addr/imem_wdata. This lasts exactly one cycle.
  - Maximum rate is one write per 2 cycles; ld_req held high through the ack cycle is not double-counted.
  - ld_done -> FLUSH. If ld_done coincides with an accepted ld_req, the write completes first and FLUSH is entered the cycle after ld_ack.
- FLUSH:
  - One cycle with cpu_en=0.
  - next_pc=RESET_PC, so pc_out=RESET_PC and the ROM presents the word at RESET_PC.
  - Then -> RUN.
- RUN:
  - cpu_en=1; each cycle pc_out <= next_pc; instret increments (wraps at 2^32).
  - next_pc priority:
    - ecall_flag: next_pc = pc_out; -> HALT. The ecall counts as committed.
    - jump_flag: next_pc = {jump_target[31:2],2'b00}; misalign_err set if jump_target[1:0]≠0.
    - otherwise: next_pc = pc_out+4 (32-bit wrap).
  - ecall_flag and jump_flag together: ecall wins and the jump is ignored.
- HALT:
  - cpu_en=0, halted=1, pc_out held, instret held, imem_we=0.
  - A resume rising edge -> RUN with next_pc = pc_out+4.
  - ld_req=1 -> LOAD, taking priority over resume in the same cycle; the request is accepted per LOAD rules starting the next cycle.
- jump_flag, ecall_flag and ld_req are ignored outside the states that use them (ld_req is used only in LOAD and HALT).
- misalign_err clears only on reset.

Test Plan:
- Boot load:
  - Stimulus: BOOT_LOAD=1; write 3 words (addr 0,1,2 = 32'h00500093, 32'h00100113, 32'h00000073), then ld_done.
  - Required: three one-cycle ld_ack/imem_we pulses with matching addr/data; FLUSH for 1 cycle; RUN with pc_out 0,4,8.
- Sequential and jump:
  - Stimulus: RUN from 0; jump_flag with jump_target=32'h40 at pc 8.
  - Required: pc_out sequence 0,4,8,0x40,0x44; imem_addr=0x10 in the cycle before pc_out=0x40.
- Ecall halt/resume:
  - Stimulus: ecall_flag at pc 0x44; hold 10 cycles; pulse resume.
  - Required: pc_out stays 0x44 with halted=1 and cpu_en=0; instret unchanged while halted; after resume, pc_out=0x48.
- Simultaneous events:
  - Stimulus: ecall_flag and jump_flag(0x100) in the same cycle.
  - Required: HALT at the current pc; no redirect.
  - Stimulus: in HALT, ld_req and a resume edge in the same cycle.
  - Required: LOAD.
- Misaligned jump:
  - Stimulus: jump_target=32'h102.
  - Required: pc_out=0x100; misalign_err=1 and remains set through later jumps.
- Reset mid-load:
  - Stimulus: drop rst_n during the ld_ack cycle.
  - Required: imem_we=0 and ld_ack=0 immediately; all outputs at reset values; after release, state LOAD and the next ld_req is accepted normally.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction-memory port arbiter: boot-loader writes in LOAD,
// CPU fetch in FLUSH/RUN/HALT, with ecall halt and button resume.
module fetch_sequencer #(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter bit          BOOT_LOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_flag,
  input  logic [31:0]       jump_target,
  input  logic              ecall_flag,
  input  logic              resume,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_done,
  output logic [31:0]       pc_out,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  output logic              ld_ack,
  output logic              cpu_en,
  output logic              halted,
  output logic              misalign_err,
  output logic [31:0]       instret,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;
  localparam logic [1:0] ST_RESET = BOOT_LOAD ? ST_LOAD : ST_FLUSH;

  // Loader handshake: ld_req is a level held until ld_ack; ld_ack pulses for the
  // single cycle in which imem_we writes the registered word, so a request still
  // high during its ack cycle is not accepted a second time.

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [31:0]       next_pc;
  logic [ADDR_W-1:0] wr_addr;
  logic              done_pend;
  logic              resume_q;
  logic              resume_rise;
  logic              accept;
  logic              misalign_set;

  assign resume_rise  = resume & ~resume_q;
  assign accept       = (state == ST_LOAD) & ld_req & ~ld_ack;
  assign misalign_set = (state == ST_RUN) & jump_flag & ~ecall_flag & (|jump_target[1:0]);

  always_comb begin
    next_pc   = pc_out;
    state_nxt = state;
    case (state)
      ST_LOAD: begin
        // A done arriving with an accepted request waits for the ack cycle.
        if (done_pend || (ld_done && !accept)) begin
          state_nxt = ST_FLUSH;
          next_pc   = RESET_PC;
        end
      end
      ST_FLUSH: begin
        next_pc   = RESET_PC;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (ecall_flag) begin
          state_nxt = ST_HALT;
        end else if (jump_flag) begin
          next_pc = {jump_target[31:2], 2'b00};
        end else begin
          next_pc = pc_out + 32'd4;
        end
      end
      default: begin
        if (ld_req) begin
          state_nxt = ST_LOAD;
        end else if (resume_rise) begin
          state_nxt = ST_RUN;
          next_pc   = pc_out + 32'd4;
        end
      end
    endcase
  end

  // Synchronous ROM: presenting next_pc now lines the fetched word up with pc_out.
  assign imem_addr = (state == ST_LOAD) ? wr_addr : next_pc[ADDR_W+1:2];
  assign cpu_en    = (state == ST_RUN);
  assign halted    = (state == ST_HALT);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RESET;
      pc_out       <= RESET_PC;
      ld_ack       <= 1'b0;
      imem_we      <= 1'b0;
      imem_wdata   <= 32'h0;
      wr_addr      <= '0;
      done_pend    <= 1'b0;
      resume_q     <= 1'b0;
      misalign_err <= 1'b0;
      instret      <= 32'h0;
    end else begin
      state     <= state_nxt;
      pc_out    <= next_pc;
      ld_ack    <= accept;
      imem_we   <= accept;
      done_pend <= accept & ld_done;
      resume_q  <= resume;
      if (accept) begin
        wr_addr    <= ld_addr;
        imem_wdata <= ld_data;
      end
      if (misalign_set) misalign_err <= 1'b1;
      if (state == ST_RUN) instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: boot load, run/jump, ecall halt/resume,
// simultaneous events, misaligned jump and reset during a loader write.
module tb_fetch_sequencer;

  localparam int AW = 14;
  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic          clk;
  logic          rst_n;
  logic          jump_flag;
  logic [31:0]   jump_target;
  logic          ecall_flag;
  logic          resume;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_done;
  logic [31:0]   pc_out;
  logic [AW-1:0] imem_addr;
  logic          imem_we;
  logic [31:0]   imem_wdata;
  logic          ld_ack;
  logic          cpu_en;
  logic          halted;
  logic          misalign_err;
  logic [31:0]   instret;
  logic [1:0]    fsm_state;

  int vectors;
  int miscompares;
  logic [31:0]      exp_q[$];
  logic [AW+31:0]   wr_q[$];
  logic [31:0]      exp_instret;

  fetch_sequencer #(.ADDR_W(AW), .RESET_PC(32'h0), .BOOT_LOAD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .jump_flag(jump_flag), .jump_target(jump_target),
    .ecall_flag(ecall_flag), .resume(resume), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_done(ld_done), .pc_out(pc_out), .imem_addr(imem_addr),
    .imem_we(imem_we), .imem_wdata(imem_wdata), .ld_ack(ld_ack), .cpu_en(cpu_en),
    .halted(halted), .misalign_err(misalign_err), .instret(instret), .fsm_state(fsm_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_pc", pc_out, 32'h0);
    check("rst_ack", {31'h0, ld_ack}, 32'h0);
    check("rst_we", {31'h0, imem_we}, 32'h0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_cpu_en", {31'h0, cpu_en}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_misalign", {31'h0, misalign_err}, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_state", {30'h0, fsm_state}, {30'h0, ST_LOAD});
  endtask

  // Pops the expected loader write and compares it with the memory port.
  task automatic check_write(input string tag);
    logic [AW+31:0] w;
    check({tag, "_ack"}, {31'h0, ld_ack}, 32'h1);
    check({tag, "_we"}, {31'h0, imem_we}, 32'h1);
    if (wr_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'h0, 32'h1);
    end else begin
      w = wr_q.pop_front();
      check({tag, "_addr"}, {18'h0, imem_addr}, {18'h0, w[AW+31:32]});
      check({tag, "_data"}, imem_wdata, w[31:0]);
    end
  endtask

  // Drives one loader word; ld_req stays high through the ack cycle.
  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d, input logic done);
    ld_req = 1'b1; ld_addr = a; ld_data = d; ld_done = done;
    wr_q.push_back({a, d});
    tick();
    ld_done = 1'b0;
    check_write("ld");
    tick();
    check("ld_single_ack", {31'h0, ld_ack}, 32'h0);
    check("ld_we_drop", {31'h0, imem_we}, 32'h0);
    ld_req = 1'b0;
  endtask

  // One RUN cycle: check fetch address ahead of the edge, PC and instret after it.
  task automatic run_step(input logic jf, input logic [31:0] jt, input logic ef,
                          input logic [31:0] exp_next);
    logic [31:0] e;
    logic [31:0] ea;
    jump_flag = jf; jump_target = jt; ecall_flag = ef;
    exp_q.push_back(exp_next);
    #1;
    ea = {18'h0, exp_next[AW+1:2]};
    check("fetch_addr", {18'h0, imem_addr}, ea);
    tick();
    jump_flag = 1'b0; ecall_flag = 1'b0;
    exp_instret = exp_instret + 32'd1;
    e = exp_q.pop_front();
    check("pc_seq", pc_out, e);
    check("instret", instret, exp_instret);
  endtask

  initial begin
    vectors = 0; miscompares = 0; exp_instret = 32'h0;
    rst_n = 1'b0; jump_flag = 1'b0; jump_target = 32'h0; ecall_flag = 1'b0;
    resume = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_data = 32'h0; ld_done = 1'b0;
    repeat (2) tick();
    check_reset_values();
    rst_n = 1'b1;
    tick();

    // Boot load; the last word carries ld_done alongside its request
    load_word(14'd0, 32'h0050_0093, 1'b0);
    load_word(14'd1, 32'h0010_0113, 1'b0);
    load_word(14'd2, 32'h0000_0073, 1'b1);
    check("flush_state", {30'h0, fsm_state}, {30'h0, ST_FLUSH});
    check("flush_cpu_en", {31'h0, cpu_en}, 32'h0);
    check("flush_pc", pc_out, 32'h0);
    check("flush_addr", {18'h0, imem_addr}, 32'h0);
    tick();
    check("run_state", {30'h0, fsm_state}, {30'h0, ST_RUN});
    check("run_cpu_en", {31'h0, cpu_en}, 32'h1);
    check("run_pc0", pc_out, 32'h0);

    // Sequential fetch and jump
    run_step(1'b0, 32'h0, 1'b0, 32'h4);
    run_step(1'b0, 32'h0, 1'b0, 32'h8);
    run_step(1'b1, 32'h40, 1'b0, 32'h40);
    run_step(1'b0, 32'h0, 1'b0, 32'h44);

    // Ecall halt, hold with stray jump requests, then resume
    run_step(1'b0, 32'h0, 1'b1, 32'h44);
    for (int i = 0; i < 10; i++) begin
      jump_flag = 1'b1; jump_target = 32'h301;
      tick();
      check("halt_pc", pc_out, 32'h44);
      check("halt_flag", {31'h0, halted}, 32'h1);
      check("halt_cpu_en", {31'h0, cpu_en}, 32'h0);
      check("halt_instret", instret, exp_instret);
    end
    jump_flag = 1'b0;
    check("halt_no_misalign", {31'h0, misalign_err}, 32'h0);
    resume = 1'b1;
    #1;
    check("resume_addr", {18'h0, imem_addr}, 32'h12);
    tick();
    check("resume_state", {30'h0, fsm_state}, {30'h0, ST_RUN});
    check("resume_pc", pc_out, 32'h48);
    check("resume_halted", {31'h0, halted}, 32'h0);
    check("resume_instret", instret, exp_instret);
    resume = 1'b0;
    run_step(1'b0, 32'h0, 1'b0, 32'h4c);

    // Ecall beats jump; then load request beats resume edge
    run_step(1'b1, 32'h100, 1'b1, 32'h4c);
    check("ecall_jump_halted", {31'h0, halted}, 32'h1);
    check("ecall_jump_misalign", {31'h0, misalign_err}, 32'h0);
    ld_req = 1'b1; resume = 1'b1; ld_addr = 14'd5; ld_data = 32'hdead_beef;
    tick();
    check("halt_ld_state", {30'h0, fsm_state}, {30'h0, ST_LOAD});
    check("halt_ld_noack", {31'h0, ld_ack}, 32'h0);
    check("halt_ld_pc", pc_out, 32'h4c);
    wr_q.push_back({ld_addr, ld_data});
    tick();
    check_write("reload");
    ld_req = 1'b0; resume = 1'b0; ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check("reload_flush", {30'h0, fsm_state}, {30'h0, ST_FLUSH});
    check("reload_flush_pc", pc_out, 32'h0);
    tick();
    check("reload_run_pc", pc_out, 32'h0);

    // Misaligned jump sets a sticky error
    run_step(1'b1, 32'h102, 1'b0, 32'h100);
    check("misalign_set", {31'h0, misalign_err}, 32'h1);
    run_step(1'b1, 32'h200, 1'b0, 32'h200);
    check("misalign_sticky", {31'h0, misalign_err}, 32'h1);
    run_step(1'b0, 32'h0, 1'b0, 32'h204);

    // Reset during a loader ack cycle
    run_step(1'b0, 32'h0, 1'b1, 32'h204);
    ld_req = 1'b1; ld_addr = 14'd7; ld_data = 32'h1234_5678;
    tick();
    check("mid_ld_state", {30'h0, fsm_state}, {30'h0, ST_LOAD});
    wr_q.push_back({ld_addr, ld_data});
    tick();
    check_write("mid_ld");
    rst_n = 1'b0;
    #1;
    exp_instret = 32'h0;
    check_reset_values();
    ld_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    load_word(14'd3, 32'hcafe_f00d, 1'b1);
    check("post_rst_flush", {30'h0, fsm_state}, {30'h0, ST_FLUSH});
    tick();
    check("post_rst_run_pc", pc_out, 32'h0);
    check("post_rst_instret", instret, 32'h0);
    run_step(1'b0, 32'h0, 1'b0, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
